// File: rtl/viterbi_decoder_k3.sv
// Hard-decision rate-1/2 K=3 (7,5) Viterbi decoder, register-exchange survivors.
// Define VITERBI_METRIC_OUT_EN to expose the final state-0 path metric (err_metric).
module viterbi_decoder_k3 #(
    parameter int FRAME_LEN = 8,
    parameter int PM_W      = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           in_sym,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [FRAME_LEN-1:0] dec_data,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef VITERBI_METRIC_OUT_EN
    ,
    output logic [PM_W-1:0]      err_metric
`endif
);

    localparam int PATH_W = FRAME_LEN + 2;
    localparam int CNT_W  = $clog2(FRAME_LEN + 2);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN + 1);
    localparam logic [3:0][PM_W-1:0] PM_INIT =
        {{3{{PM_W{1'b1}}}}, {PM_W{1'b0}}};

    typedef enum logic {ACC, OUT} state_t;

    state_t                     state;
    state_t                     stateNext;
    logic [CNT_W-1:0]           count;
    logic [3:0][PM_W-1:0]       pm;
    logic [3:0][PM_W-1:0]       pmNext;
    logic [3:0][PATH_W-1:0]     path;
    logic [3:0][PATH_W-1:0]     pathNext;
    logic                       accept;
    logic                       outXfer;
    logic                       lastSym;

    function automatic logic [1:0] branchMetric(
        input logic [1:0] sym,
        input logic [1:0] pred,
        input logic       u
    );
        logic c0;
        logic c1;
        c0 = u ^ pred[1] ^ pred[0];
        c1 = u ^ pred[0];
        return {1'b0, sym[1] ^ c0} + {1'b0, sym[0] ^ c1};
    endfunction

    function automatic logic [PM_W-1:0] satAdd(
        input logic [PM_W-1:0] a,
        input logic [1:0]      b
    );
        logic [PM_W:0] sum;
        sum = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
        return sum[PM_W] ? {PM_W{1'b1}} : sum[PM_W-1:0];
    endfunction

    // Next state ns is reached from {ns[0],0} or {ns[0],1} with input u=ns[1]
    for (genvar g = 0; g < 4; g++) begin : gAcs
        localparam logic [1:0] NS = 2'(g);
        localparam logic       U  = NS[1];
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};

        logic [PM_W-1:0]   cand0;
        logic [PM_W-1:0]   cand1;
        logic              pick1;
        logic [PATH_W-1:0] surv;

        assign cand0 = satAdd(pm[P0], branchMetric(in_sym, P0, U));
        assign cand1 = satAdd(pm[P1], branchMetric(in_sym, P1, U));
        assign pick1 = cand1 < cand0;
        assign surv  = pick1 ? path[P1] : path[P0];
        assign pmNext[g]   = pick1 ? cand1 : cand0;
        assign pathNext[g] = (surv << 1) | PATH_W'(U);
    end

    assign accept  = in_valid & in_ready;
    assign outXfer = out_valid & out_ready;
    assign lastSym = (count == LAST_CNT);

    always_comb begin
        stateNext = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && lastSym) stateNext = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) stateNext = ACC;
            end
            default: stateNext = ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACC;
        else        state <= stateNext;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count    <= '0;
            pm       <= PM_INIT;
            path     <= '0;
            dec_data <= '0;
        end else if (accept) begin
            count <= count + 1'b1;
            pm    <= pmNext;
            path  <= pathNext;
            // Tail bits sit in the two LSBs of the state-0 survivor
            if (lastSym) dec_data <= pathNext[0][PATH_W-1:2];
        end else if (outXfer) begin
            count <= '0;
            pm    <= PM_INIT;
            path  <= '0;
        end
    end

`ifdef VITERBI_METRIC_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  err_metric <= '0;
        else if (accept && lastSym)  err_metric <= pmNext[0];
    end
`endif

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Directed bench for viterbi_decoder_k3: clean, corrupted, zero, gapped and reset frames.
module tb_viterbi_decoder_k3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] in_sym;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dec_data;
    logic       out_valid;
    logic       out_ready;
`ifdef VITERBI_METRIC_OUT_EN
    logic [5:0] err_metric;
`endif

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [19:0] CLEAN   = 20'b11_10_00_10_11_11_10_00_10_11;
    localparam logic [19:0] ONE_ERR = 20'b11_10_01_10_11_11_10_00_10_11;
    localparam logic [19:0] ZEROS   = 20'b0;

    always #5 clk = ~clk;

    viterbi_decoder_k3 #(.FRAME_LEN(8), .PM_W(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sym    (in_sym),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dec_data  (dec_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef VITERBI_METRIC_OUT_EN
        ,
        .err_metric(err_metric)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendSym(input logic [1:0] s);
        int n;
        n = 0;
        in_sym   = s;
        in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) check("in_ready_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sendFrame(input logic [19:0] f, input bit gaps);
        for (int i = 0; i < 10; i++) begin
            if (i == 9) check("early_out_valid", 32'(out_valid), 32'd0);
            sendSym(f[19-2*i -: 2]);
            if (gaps && i < 9) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic frameResult(input string tag, input logic [7:0] expData,
                               input logic [5:0] expMetric);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_ready"}, 32'(in_ready), 32'd0);
        check({tag, "_data"}, 32'(dec_data), 32'(expData));
`ifdef VITERBI_METRIC_OUT_EN
        check({tag, "_metric"}, 32'(err_metric), 32'(expMetric));
`else
        if (expMetric != 6'd0 && expMetric == 6'd63) $display("metric n/a");
`endif
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("xfer_valid", 32'(out_valid), 32'd0);
        check("xfer_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sym    = 2'b00;
        out_ready = 1'b0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_dec_data", 32'(dec_data), 32'd0);
`ifdef VITERBI_METRIC_OUT_EN
        check("rst_err_metric", 32'(err_metric), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        sendFrame(CLEAN, 1'b0);
        frameResult("clean", 8'hA5, 6'd0);
        consume();

        sendFrame(ONE_ERR, 1'b0);
        frameResult("one_err", 8'hA5, 6'd1);
        consume();

        sendFrame(ZEROS, 1'b0);
        frameResult("zeros", 8'h00, 6'd0);
        consume();

        sendFrame(CLEAN, 1'b0);
        frameResult("reinit", 8'hA5, 6'd0);
        consume();

        out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("idle_oready_valid", 32'(out_valid), 32'd0);
        check("idle_oready_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b0;

        sendFrame(CLEAN, 1'b1);
        frameResult("gapped", 8'hA5, 6'd0);
        in_sym   = 2'b11;
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_ready", 32'(in_ready), 32'd0);
            check("hold_data", 32'(dec_data), 32'hA5);
        end
        in_valid = 1'b0;
        consume();
        sendFrame(ONE_ERR, 1'b0);
        frameResult("after_hold", 8'hA5, 6'd1);
        consume();

        for (int i = 0; i < 4; i++) sendSym(CLEAN[19-2*i -: 2]);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        check("midrst_data", 32'(dec_data), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        sendFrame(CLEAN, 1'b0);
        frameResult("post_rst", 8'hA5, 6'd0);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
